// File: rtl/uart_pkg.sv
// uart_pkg: items shared by the UART receiver and the future transmitter.
//   - DEFAULT_CLK_FREQ / DEFAULT_BAUD : default parameter values
//   - uart_state_e                    : receiver FSM state encoding
//   - clks_per_bit()                  : clock cycles per serial bit
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD     = 9600;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

    // Integer division; any fractional remainder is dropped.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through byte FIFO for the UART receiver.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, wdata     : write request and byte; dropped when full unless a pop
//                     happens in the same cycle
//   pop             : removes the head entry; ignored when empty
//   rdata           : oldest entry (zero after reset)
//   empty, full     : occupancy flags
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign rdata = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a small receive FIFO.
// Ports:
//   clk, rst_pin  : clock, asynchronous active-high reset
//   uart_rx_in    : asynchronous serial input, idles high
//   rx_data       : byte at the FIFO head
//   rx_valid      : FIFO not empty
//   rx_rd         : pop the head entry (ignored when rx_valid is low)
//   frame_err     : one-cycle pulse when a stop bit samples low
//   overflow      : sticky; a received byte was dropped on a full FIFO
//   state_dbg     : current receiver FSM state
//
// Handshake: an entry is consumed on a rising clk edge where rx_valid and
// rx_rd are both high; rx_data holds while rx_valid is high and rx_rd is low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_pin,
    input  logic        uart_rx_in,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_rd,
    output logic        frame_err,
    output logic        overflow,
    output uart_state_e state_dbg
);

    localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TIMER_W = $clog2(CPB);
    localparam logic [TIMER_W-1:0] HALF_M1 = TIMER_W'(CPB / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_M1 = TIMER_W'(CPB - 1);

    logic               rx_s1_q, rx_s2_q;
    logic               rx_sync;
    uart_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               frame_err_q, frame_err_d;
    logic               overflow_q, overflow_d;
    logic               push;
    logic               fifo_empty;
    logic               fifo_full;

    assign rx_sync   = rx_s2_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign rx_valid  = !fifo_empty;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (!rx_sync) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (timer_q == HALF_M1) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d   = '0;
                    shift_d   = {rx_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    if (rx_sync) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) must not look like a new start bit.
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A push on a full FIFO is lost unless a pop frees a slot in the same cycle.
    always_comb begin
        overflow_d = overflow_q | (push && fifo_full && !(rx_rd && !fifo_empty));
    end

    always_ff @(posedge clk or posedge rst_pin) begin
        if (rst_pin) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rx_s1_q     <= uart_rx_in;
            rx_s2_q     <= rx_s1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // The shift register feeds the FIFO directly so rx_valid rises the cycle
    // after the stop-bit sample.
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_pin),
        .push  (push),
        .wdata (shift_q),
        .pop   (rx_rd),
        .rdata (rx_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx, run at 16 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic        clk;
    logic        rst_pin;
    logic        uart_rx_in;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_rd;
    logic        frame_err;
    logic        overflow;
    uart_state_e state_dbg;

    int checks;
    int errors;
    int fe_cnt;
    int fe_base;

    uart_rx #(
        .CLK_FREQ   (100_000_000),
        .BAUD       (6_250_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_pin    (rst_pin),
        .uart_rx_in (uart_rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_rd      (rx_rd),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Driver: called right after a negedge; returns after the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit check_lat);
        uart_rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_in = stop_bit;
        if (check_lat) begin
            repeat (CPB / 2) @(negedge clk);
            check("lat_at_stop_mid", {7'd0, rx_valid}, 8'h00);
            repeat (3) @(negedge clk);
            check("lat_mid_plus3", {7'd0, rx_valid}, 8'h01);
            repeat (CPB / 2 - 3) @(negedge clk);
        end else begin
            repeat (CPB) @(negedge clk);
        end
        uart_rx_in = 1'b1;
    endtask

    task automatic pop_one();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic do_reset();
        rst_pin = 1'b1;
        repeat (4) @(negedge clk);
        rst_pin = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        checks     = 0;
        errors     = 0;
        fe_cnt     = 0;
        rst_pin    = 1'b1;
        uart_rx_in = 1'b1;
        rx_rd      = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        check("rst_frame_err", {7'd0, frame_err}, 8'h00);
        check("rst_overflow", {7'd0, overflow}, 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_state", 8'(state_dbg), 8'(ST_IDLE));
        rst_pin = 1'b0;
        repeat (20) @(negedge clk);

        // Single byte with latency check, then pop
        send_byte(8'h53, 1'b1, 1'b1);
        check("single_data", rx_data, 8'h53);
        repeat (5) @(negedge clk);
        check("single_data_held", rx_data, 8'h53);
        pop_one();
        check("single_popped", {7'd0, rx_valid}, 8'h00);

        // Two back-to-back bytes, FIFO ordering
        send_byte(8'h53, 1'b1, 1'b0);
        send_byte(8'h41, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("b2b_valid", {7'd0, rx_valid}, 8'h01);
        check("b2b_head0", rx_data, 8'h53);
        pop_one();
        check("b2b_head1", rx_data, 8'h41);
        pop_one();
        check("b2b_empty", {7'd0, rx_valid}, 8'h00);
        check("b2b_no_fe", 8'(fe_cnt), 8'h00);

        // Short low glitch on the line
        uart_rx_in = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_state", 8'(state_dbg), 8'(ST_IDLE));
        check("glitch_valid", {7'd0, rx_valid}, 8'h00);
        check("glitch_no_fe", 8'(fe_cnt), 8'h00);

        // Bad stop bit followed by a held-low line, then a good byte
        fe_base = fe_cnt;
        send_byte(8'h41, 1'b0, 1'b0);
        uart_rx_in = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("brk_state", 8'(state_dbg), 8'(ST_WAIT_IDLE));
        uart_rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_state_idle", 8'(state_dbg), 8'(ST_IDLE));
        check("brk_one_fe", 8'(fe_cnt - fe_base), 8'h01);
        check("brk_no_push", {7'd0, rx_valid}, 8'h00);
        send_byte(8'h53, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("after_brk_data", rx_data, 8'h53);
        pop_one();
        check("after_brk_empty", {7'd0, rx_valid}, 8'h00);

        // Overflow: five bytes into a four-entry FIFO
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
        end
        check("ovf_not_yet", {7'd0, overflow}, 8'h00);
        send_byte(8'h05, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("ovf_set", {7'd0, overflow}, 8'h01);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_pop%0d", i), rx_data, 8'(i));
            pop_one();
        end
        check("ovf_empty", {7'd0, rx_valid}, 8'h00);
        repeat (10) @(negedge clk);
        check("ovf_sticky", {7'd0, overflow}, 8'h01);
        do_reset();
        check("ovf_cleared", {7'd0, overflow}, 8'h00);

        // Reset during data bit 3 of 0x53, then receive 0x41
        fe_base = fe_cnt;
        uart_rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_rx_in = 1'((8'h53 >> i) & 8'h01);
            repeat (CPB) @(negedge clk);
        end
        uart_rx_in = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst_pin = 1'b1;
        uart_rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst_pin = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_valid", {7'd0, rx_valid}, 8'h00);
        check("midrst_state", 8'(state_dbg), 8'(ST_IDLE));
        send_byte(8'h41, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("midrst_data", rx_data, 8'h41);
        pop_one();
        check("midrst_only_one", {7'd0, rx_valid}, 8'h00);
        check("midrst_no_fe", 8'(fe_cnt - fe_base), 8'h00);
        check("midrst_no_ovf", {7'd0, overflow}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
